// File: rtl/proc_defs.sv
// ---------------------------------------------------------------------------
// proc_defs
// Shared definitions for the instruction fetch path of the multi-cycle
// processor: data/address widths, the NOP word, the opcode field values the
// controller decodes, the fetch FSM state encoding and a word-alignment helper.
// ---------------------------------------------------------------------------
package proc_defs;

  localparam int INSTR_W = 32;
  localparam int ADDR_W  = 32;

  localparam logic [INSTR_W-1:0] NOP_WORD = 32'h0000_0000;

  // Opcode field lives in instruction[31:26]
  localparam logic [5:0] OP_MOV = 6'h02;
  localparam logic [5:0] OP_CPY = 6'h03;
  localparam logic [5:0] OP_LDI = 6'h0A;

  typedef enum logic [1:0] {
    FETCH_IDLE = 2'd0,
    FETCH_REQ  = 2'd1,
    FETCH_HALT = 2'd2
  } fetch_state_e;

  // Instruction addresses are word aligned: the two low bits are dropped.
  function automatic logic [ADDR_W-1:0] align_word(input logic [ADDR_W-1:0] addr);
    return {addr[ADDR_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/instr_fetch_queue_fetch_fifo.sv
// ---------------------------------------------------------------------------
// fetch_fifo
// DEPTH-entry circular buffer holding fetched words together with the address
// each word came from.
// Ports:
//   clk, reset (async, active low)
//   flush            - empties the buffer; overrides push and pop
//   push, push_data, push_addr - write one word/address pair
//   pop              - drop the head entry (ignored when empty)
//   count            - occupancy 0..DEPTH
//   head_data, head_addr - oldest entry (meaningful only when count != 0)
// ---------------------------------------------------------------------------
module fetch_fifo
  import proc_defs::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          flush,
  input  logic                          push,
  input  logic [INSTR_W-1:0]            push_data,
  input  logic [ADDR_W-1:0]             push_addr,
  input  logic                          pop,
  output logic [$clog2(DEPTH):0]        count,
  output logic [INSTR_W-1:0]            head_data,
  output logic [ADDR_W-1:0]             head_addr
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [INSTR_W-1:0] data_r [DEPTH];
  logic [ADDR_W-1:0]  addr_r [DEPTH];
  logic [PTR_W-1:0]   rd_ptr_r;
  logic [PTR_W-1:0]   wr_ptr_r;
  logic [CNT_W-1:0]   count_r;
  logic               pop_ok_s;
  logic               push_ok_s;

  // Qualify requests: flush wins, pops need data, pushes need room unless a pop frees a slot.
  always_comb begin
    pop_ok_s  = 1'b0;
    push_ok_s = 1'b0;
    if (flush) begin
      pop_ok_s  = 1'b0;
      push_ok_s = 1'b0;
    end else begin
      pop_ok_s  = pop && (count_r != {CNT_W{1'b0}});
      push_ok_s = push && ((count_r < FULL_CNT) || pop_ok_s);
    end
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr_r <= {PTR_W{1'b0}};
      wr_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else if (flush) begin
      rd_ptr_r <= {PTR_W{1'b0}};
      wr_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      if (push_ok_s && !pop_ok_s) begin
        count_r <= count_r + CNT_W'(1);
      end else if (pop_ok_s && !push_ok_s) begin
        count_r <= count_r - CNT_W'(1);
      end
    end
  end

  // Entry storage; no reset needed because consumers gate the head with count.
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      data_r[wr_ptr_r] <= push_data;
      addr_r[wr_ptr_r] <= push_addr;
    end
  end

  assign count     = count_r;
  assign head_data = data_r[rd_ptr_r];
  assign head_addr = addr_r[rd_ptr_r];

endmodule

// File: rtl/instr_fetch_queue.sv
// ---------------------------------------------------------------------------
// instr_fetch_queue
// Fetch stage for the multi-cycle processor: issues one word fetch at a time
// to instruction memory, buffers returned words in a prefetch queue and
// presents the oldest word to the controller.
// Ports:
//   clk, reset (async, active low)
//   mem_addr/mem_req/mem_ack/mem_data - single-outstanding memory handshake
//   instruction/instr_valid/fetch_pc  - head of queue and its address
//   instr_take                        - controller consumed the head word
//   redirect/redirect_pc              - flush and restart at a new address
//   sys_dne                           - processor halted, stop fetching
// Build option: define INSTR_BYPASS_EN to forward an acked word straight to
// the outputs in its ack cycle when the queue is empty (zero latency).
// ---------------------------------------------------------------------------
module instr_fetch_queue
  import proc_defs::*;
#(
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = 32'h0000_0000,
  parameter logic [ADDR_W-1:0] PC_STEP  = 32'h0000_0004
) (
  input  logic               clk,
  input  logic               reset,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic               mem_req,
  input  logic               mem_ack,
  input  logic [INSTR_W-1:0] mem_data,
  output logic [INSTR_W-1:0] instruction,
  output logic               instr_valid,
  input  logic               instr_take,
  input  logic               redirect,
  input  logic [ADDR_W-1:0]  redirect_pc,
  input  logic               sys_dne,
  output logic [ADDR_W-1:0]  fetch_pc
);

  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  fetch_state_e       state_r;
  fetch_state_e       state_s;
  logic [ADDR_W-1:0]  pc_r;
  logic               discard_r;
  logic               issue_s;
  logic               accept_s;
  logic               bypass_s;
  logic               push_s;
  logic [CNT_W-1:0]   count_s;
  logic [INSTR_W-1:0] head_data_s;
  logic [ADDR_W-1:0]  head_addr_s;

  // An ack is kept only when it answers a live request that no redirect has invalidated.
  assign accept_s = (state_r == FETCH_REQ) && mem_ack && !discard_r && !redirect;

`ifdef INSTR_BYPASS_EN
  assign bypass_s = accept_s && (count_s == {CNT_W{1'b0}});
`else
  assign bypass_s = 1'b0;
`endif

  // A bypassed word that is taken in the same cycle never enters the queue.
  assign push_s = accept_s && !(bypass_s && instr_take);

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .flush     (redirect),
    .push      (push_s),
    .push_data (mem_data),
    .push_addr (mem_addr),
    .pop       (instr_take),
    .count     (count_s),
    .head_data (head_data_s),
    .head_addr (head_addr_s)
  );

  // Fetch FSM next state; a redirect seen in IDLE holds there one cycle so the next fetch uses the new pc.
  always_comb begin
    state_s = state_r;
    issue_s = 1'b0;
    case (state_r)
      FETCH_IDLE: begin
        if (redirect) begin
          state_s = FETCH_IDLE;
        end else if (sys_dne) begin
          state_s = FETCH_HALT;
        end else if (count_s < FULL_CNT) begin
          state_s = FETCH_REQ;
          issue_s = 1'b1;
        end else begin
          state_s = FETCH_IDLE;
        end
      end
      FETCH_REQ: begin
        if (mem_ack) begin
          state_s = (sys_dne && !redirect) ? FETCH_HALT : FETCH_IDLE;
        end else begin
          state_s = FETCH_REQ;
        end
      end
      FETCH_HALT: begin
        if (redirect) begin
          state_s = FETCH_IDLE;
        end else begin
          state_s = FETCH_HALT;
        end
      end
      default: begin
        state_s = FETCH_IDLE;
      end
    endcase
  end

  // State, program counter, request handshake and discard tracking.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r   <= FETCH_IDLE;
      pc_r      <= RESET_PC;
      mem_addr  <= RESET_PC;
      mem_req   <= 1'b0;
      discard_r <= 1'b0;
    end else begin
      state_r <= state_s;

      if (redirect) begin
        pc_r <= align_word(redirect_pc);
      end else if (accept_s) begin
        pc_r <= pc_r + PC_STEP;
      end

      if (issue_s) begin
        mem_addr <= pc_r;
        mem_req  <= 1'b1;
      end else if ((state_r == FETCH_REQ) && mem_ack) begin
        mem_req <= 1'b0;
      end

      // The ack closes the transaction; a redirect while still waiting marks it stale.
      if ((state_r == FETCH_REQ) && mem_ack) begin
        discard_r <= 1'b0;
      end else if ((state_r == FETCH_REQ) && redirect) begin
        discard_r <= 1'b1;
      end
    end
  end

  // Head-of-queue presentation; fetch_pc shows the next fetch address while empty.
  always_comb begin
    instruction = NOP_WORD;
    instr_valid = 1'b0;
    fetch_pc    = pc_r;
    if (count_s != {CNT_W{1'b0}}) begin
      instruction = head_data_s;
      instr_valid = 1'b1;
      fetch_pc    = head_addr_s;
    end else if (bypass_s) begin
      instruction = mem_data;
      instr_valid = 1'b1;
      fetch_pc    = mem_addr;
    end else begin
      instruction = NOP_WORD;
      instr_valid = 1'b0;
      fetch_pc    = pc_r;
    end
  end

endmodule

// File: doc/instr_fetch_queue.md
Name: instr_fetch_queue

Overview:
- Upstream fetch stage for the multi-cycle `processor`. Issues word fetches to instruction memory and buffers returned words in a small prefetch queue.
- Presents the oldest word on `instruction` with a valid flag. The controller pulses `instr_take` when it latches the word in its fetch state.
- Supports PC redirect (jump/branch) and halts fetching on `sys_dne`.

Parameters:
- DEPTH, 4, queue entries; power of two, 2..16.
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- PC_STEP, 4, byte increment between sequential fetches.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- mem_addr  out  32  fetch address; stable while mem_req=1.
- mem_req  out  1  fetch request; held until mem_ack.
- mem_ack  in  1  one-cycle pulse; mem_data valid that cycle.
- mem_data  in  32  returned instruction word.
- instruction  out  32  head-of-queue word; connects to processor.instruction.
- instr_valid  out  1  head entry valid.
- instr_take  in  1  pop head; ignored when instr_valid=0.
- redirect  in  1  one-cycle pulse: flush queue, restart at redirect_pc.
- redirect_pc  in  32  new fetch address; bits [1:0] forced to 0.
- sys_dne  in  1  processor halted; stop issuing fetches.
- fetch_pc  out  32  address of the head word (valid when instr_valid=1).

Behaviour:
- Reset (async, reset=0) sets:
  - pc=RESET_PC; queue empty (rd_ptr=wr_ptr=0, count=0).
  - mem_req=0, mem_addr=RESET_PC, instruction=32'h0, instr_valid=0, fetch_pc=RESET_PC.
  - FSM=IDLE; discard flag cleared.
  - Reset mid-request drops the request; a late mem_ack after reset is ignored.
- FSM states IDLE, REQ, HALT:
  - IDLE -> REQ when sys_dne=0 and count < DEPTH. Load mem_addr=pc, raise mem_req next cycle.
  - REQ: hold mem_req and mem_addr until mem_ack.
    - On ack, if not discarding, write mem_data at wr_ptr along with its address, and advance pc by PC_STEP (32-bit wrap, FFFF_FFFC -> 0).
    - Then go to IDLE, or HALT if sys_dne=1.
  - HALT: mem_req=0. Leave only on redirect (-> IDLE) or reset. The queue keeps draining via instr_take.
- At most one request outstanding; the request is never withdrawn before ack.
- Queue:
  - Circular buffer, log2(DEPTH)-bit pointers with wrap, count 0..DEPTH.
  - A request is issued only when count < DEPTH, so ack-when-full cannot occur.
  - Simultaneous ack and take: count unchanged, both pointers advance; legal at count=DEPTH-1 and at count=DEPTH via take.
  - Take when empty: no effect.
- Output is registered/head-driven:
  - instruction = head word when count>0, else 32'h0.
  - instr_valid = (count != 0).
  - An acked word appears on instruction one cycle after mem_ack (latency 1, no bypass).
- Redirect:
  - Same cycle: count=0, pointers cleared, pc=redirect_pc.
  - If in REQ, set discard; the pending ack is consumed and dropped, then a new fetch at the new pc is issued.
  - Redirect and take in the same cycle: redirect wins.
  - Redirect and ack in the same cycle: ack data dropped.
- sys_dne while IDLE -> HALT immediately; while in REQ, finish the transaction first.

Optional Feature:
- INSTR_BYPASS_EN defined: when count=0 and mem_ack=1 without discard, instruction=mem_data and instr_valid=1 combinationally in the ack cycle. If instr_take is also 1, the word is consumed and not written (latency 0).
- Undefined: latency 1 as above.

Decomposition:
- Shared package/include `proc_defs`:
  - INSTR_W=32, ADDR_W=32, NOP word 32'h0.
  - Opcode constants (instruction[31:26]): OP_MOV=6'h02, OP_CPY=6'h03, OP_LDI=6'h0A.
  - FSM state encodings.
- One sub-module, `fetch_fifo`: DEPTH-entry circular buffer with push/pop/flush, count, head data+address. The fetch FSM lives in instr_fetch_queue.

Test Plan:
- Reset low, then high; memory returns 28E0A51B, 08E80000, 0D070000 at 0,4,8 with 1-cycle ack -> mem_addr sequence 0,4,8,C; instruction=28E0A51B with instr_valid=1 one cycle after first ack; pops in order on instr_take; fetch_pc 0,4,8.
- No instr_take, memory always acks -> exactly 4 words queued, mem_req stays 0 while count=4. One take -> a new request at addr 10.
- Take and ack in the same cycle at count=3 -> count stays 3, order preserved, no word lost.
- Redirect to 32'h100 while a request to 8 is pending; ack data DEADBEEF -> DEADBEEF discarded, queue empty, next mem_addr=100, first valid word is from 100.
- sys_dne=1 -> no new mem_req after the in-flight ack; queue drains to instr_valid=0, instruction=0. Redirect to 0 resumes fetching.
- Assert reset mid-REQ, then apply a late mem_ack -> all outputs at reset values, ack ignored, first fetch after release at RESET_PC.
